// File: rtl/double_framebuffer.sv
// double_framebuffer: two-bank framebuffer. Bank swaps are deferred to vsync so scan-out never tears.
// Optional back-bank fill engine is built when DOUBLE_FRAMEBUFFER_CLEAR_EN is defined.
module double_framebuffer #(
    parameter int WIDTH        = 160,
    parameter int HEIGHT       = 120,
    parameter int BITSPERPIXEL = 8,
    parameter int COORDBITS    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COORDBITS-1:0]    x,
    input  logic [COORDBITS-1:0]    y,
    input  logic [BITSPERPIXEL-1:0] color,
    input  logic                    write,
    input  logic [COORDBITS-1:0]    x_data,
    input  logic [COORDBITS-1:0]    y_data,
    output logic [BITSPERPIXEL-1:0] pixel_data,
    input  logic                    vsync,
    input  logic                    swap_req,
    output logic                    swap_pending,
    output logic                    swap_done,
    output logic                    front_sel,
    input  logic                    clear_start,
    input  logic [BITSPERPIXEL-1:0] clear_color,
    output logic                    busy
);
    localparam int PIXELS = WIDTH * HEIGHT;
    localparam int ADDR_W = $clog2(PIXELS);
    localparam logic [COORDBITS:0] W_LIM = (COORDBITS+1)'(WIDTH);
    localparam logic [COORDBITS:0] H_LIM = (COORDBITS+1)'(HEIGHT);

    logic [BITSPERPIXEL-1:0] bank0 [PIXELS];
    logic [BITSPERPIXEL-1:0] bank1 [PIXELS];

    logic                    draw_in, read_in;
    logic [ADDR_W-1:0]       draw_addr, read_addr;
    logic                    fill_we;
    logic [ADDR_W-1:0]       fill_addr;
    logic [BITSPERPIXEL-1:0] fill_data;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [BITSPERPIXEL-1:0] mem_data;
    logic                    swap_go;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORDBITS-1:0] px,
                                                   input logic [COORDBITS-1:0] py);
        return ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
    endfunction

    assign draw_in   = ({1'b0, x} < W_LIM) && ({1'b0, y} < H_LIM);
    assign read_in   = ({1'b0, x_data} < W_LIM) && ({1'b0, y_data} < H_LIM);
    assign draw_addr = pix_addr(x, y);
    assign read_addr = pix_addr(x_data, y_data);

    // The fill engine owns the write port while busy; draw writes are dropped then.
    assign mem_we   = fill_we | (write & draw_in & ~busy);
    assign mem_addr = fill_we ? fill_addr : draw_addr;
    assign mem_data = fill_we ? fill_data : color;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (front_sel) bank0[mem_addr] <= mem_data;
            else           bank1[mem_addr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pixel_data <= '0;
        else if (read_in) pixel_data <= front_sel ? bank1[read_addr] : bank0[read_addr];
        else              pixel_data <= '0;
    end

    // A request in the same cycle as vsync is only registered; pending requests are absorbed.
    assign swap_go = vsync & swap_pending & ~busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            front_sel <= front_sel ^ swap_go;
            swap_done <= swap_go;
            if (swap_go)       swap_pending <= 1'b0;
            else if (swap_req) swap_pending <= 1'b1;
        end
    end

`ifdef DOUBLE_FRAMEBUFFER_CLEAR_EN
    // state  | meaning
    // S_IDLE | waiting for clear_start
    // S_FILL | writing latched colour to back[fill_cnt], one pixel per cycle
    typedef enum logic {S_IDLE, S_FILL} fill_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    fill_state_t             state, state_nx;
    logic [ADDR_W-1:0]       fill_cnt;
    logic [BITSPERPIXEL-1:0] fill_color;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (clear_start) state_nx = S_FILL;
            S_FILL: if (fill_cnt == LAST_ADDR) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == S_FILL);
        fill_we = (state == S_FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt   <= '0;
            fill_color <= '0;
        end else if (state == S_IDLE && clear_start) begin
            fill_cnt   <= '0;
            fill_color <= clear_color;
        end else if (state == S_FILL && fill_cnt != LAST_ADDR) begin
            fill_cnt <= fill_cnt + ADDR_W'(1);
        end
    end

    assign fill_addr = fill_cnt;
    assign fill_data = fill_color;
`else
    logic unused_clear;

    assign unused_clear = ^{clear_start, clear_color};
    assign busy         = 1'b0;
    assign fill_we      = 1'b0;
    assign fill_addr    = '0;
    assign fill_data    = '0;
`endif

endmodule

// File: tb/tb_double_framebuffer.sv
// Self-checking bench for double_framebuffer: directed steps plus random traffic against a
// pixel-array reference model; a second instance covers a 320x240x16 configuration.
module tb_double_framebuffer;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] x = '0, y = '0, x_data = '0, y_data = '0;
    logic [7:0] color = '0, clear_color = '0, pixel_data;
    logic       write = 1'b0, vsync = 1'b0, swap_req = 1'b0, clear_start = 1'b0;
    logic       swap_pending, swap_done, front_sel, busy;

    logic [8:0]  wx = '0, wy = '0, wxd = '0, wyd = '0;
    logic [15:0] wcolor = '0, wclear_color = '0, wpixel;
    logic        ww = 1'b0, wvs = 1'b0, wsr = 1'b0, wcs = 1'b0;
    logic        wpend, wdone, wfront, wbusy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    double_framebuffer dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .color(color), .write(write),
        .x_data(x_data), .y_data(y_data), .pixel_data(pixel_data), .vsync(vsync),
        .swap_req(swap_req), .swap_pending(swap_pending), .swap_done(swap_done),
        .front_sel(front_sel), .clear_start(clear_start), .clear_color(clear_color), .busy(busy)
    );

    double_framebuffer #(.WIDTH(320), .HEIGHT(240), .BITSPERPIXEL(16), .COORDBITS(9)) dut_wide (
        .clk(clk), .rst_n(rst_n), .x(wx), .y(wy), .color(wcolor), .write(ww),
        .x_data(wxd), .y_data(wyd), .pixel_data(wpixel), .vsync(wvs),
        .swap_req(wsr), .swap_pending(wpend), .swap_done(wdone),
        .front_sel(wfront), .clear_start(wcs), .clear_color(wclear_color), .busy(wbusy)
    );

    // Reference model: banks as plain arrays, knowledge flags for never-written pixels.
    logic [7:0] m_bank [2][N];
    bit         m_known [2][N];
    bit         m_front, m_pend, m_done, m_pix_known;
    logic [7:0] m_pix;
    int         m_fill_left, m_fill_idx;
    logic [7:0] m_fill_color;

    task automatic model_reset();
        m_front = 0; m_pend = 0; m_done = 0;
        m_pix = '0; m_pix_known = 1;
        m_fill_left = 0; m_fill_idx = 0;
    endtask

    task automatic model_edge();
        bit busy_pre;
        int rx, ry, wxi, wyi;
        busy_pre = (m_fill_left > 0);
        rx = int'(x_data); ry = int'(y_data);
        if (rx < W && ry < H) begin
            m_pix_known = m_known[m_front][ry*W+rx];
            m_pix       = m_bank[m_front][ry*W+rx];
        end else begin
            m_pix_known = 1; m_pix = '0;
        end
        wxi = int'(x); wyi = int'(y);
        if (busy_pre) begin
            m_bank[!m_front][m_fill_idx]  = m_fill_color;
            m_known[!m_front][m_fill_idx] = 1;
            m_fill_idx++; m_fill_left--;
        end else if (write && wxi < W && wyi < H) begin
            m_bank[!m_front][wyi*W+wxi]  = color;
            m_known[!m_front][wyi*W+wxi] = 1;
        end
`ifdef DOUBLE_FRAMEBUFFER_CLEAR_EN
        if (!busy_pre && clear_start) begin
            m_fill_left = N; m_fill_idx = 0; m_fill_color = clear_color;
        end
`endif
        m_done = 0;
        if (vsync && m_pend && !busy_pre) begin
            m_front = !m_front; m_pend = 0; m_done = 1;
        end else if (swap_req) begin
            m_pend = 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("swap_pending", 32'(swap_pending), 32'(m_pend));
        check("swap_done", 32'(swap_done), 32'(m_done));
        check("busy", 32'(busy), 32'(m_fill_left > 0));
        if (m_pix_known) check("pixel_data", 32'(pixel_data), 32'(m_pix));
    endtask

    task automatic quiet();
        write = 0; vsync = 0; swap_req = 0; clear_start = 0;
    endtask

    task automatic draw(input int px, input int py, input logic [7:0] c);
        write = 1; x = 8'(px); y = 8'(py); color = c;
        cyc();
        write = 0;
    endtask

    task automatic do_swap();
        swap_req = 1; cyc(); swap_req = 0;
        vsync = 1; cyc(); vsync = 0;
    endtask

`ifdef DOUBLE_FRAMEBUFFER_CLEAR_EN
    task automatic run_fill(input logic [7:0] c, input string tag);
        int bc;
        clear_start = 1; clear_color = c;
        cyc();
        clear_start = 0;
        bc = 0;
        for (int i = 0; i < N + 5; i++) begin
            if (busy !== 1'b1) break;
            bc++;
            write = 1; x = 8'($urandom_range(0, W-1)); y = 8'($urandom_range(0, H-1));
            color = 8'($urandom);
            clear_start = (i == 50);
            swap_req = (i == 100);
            vsync = (i == 200 || i == 300);
            cyc();
        end
        quiet();
        check(tag, 32'(bc), 32'(N));
    endtask
`endif

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pixel", 32'(pixel_data), 32'h0);
        check("rst_front", 32'(front_sel), 32'h0);
        check("rst_pending", 32'(swap_pending), 32'h0);
        check("rst_done", 32'(swap_done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Back-bank write stays hidden until a vsync swap.
        x_data = 8'd3; y_data = 8'd2;
        draw(3, 2, 8'h5A);
        cyc();
        checks++;
        assert (pixel_data !== 8'h5A) else begin
            failures++;
            $error("FAIL back_hidden observed=%0h expected=not 5a", pixel_data);
        end
        do_swap();
        check("swap_front", 32'(front_sel), 32'h1);
        check("swap_done_pulse", 32'(swap_done), 32'h1);
        cyc();
        check("swapped_pixel", 32'(pixel_data), 32'h5A);
        check("swap_done_once", 32'(swap_done), 32'h0);

        // Out-of-range writes must not alias into the array.
        draw(0, 0, 8'h33);
        draw(0, 1, 8'h44);
        draw(160, 0, 8'hFF);
        draw(0, 120, 8'hFF);
        do_swap();
        x_data = 8'd200; y_data = 8'd5; cyc();
        check("oob_read", 32'(pixel_data), 32'h0);
        x_data = 8'd0; y_data = 8'd0; cyc();
        check("origin_kept", 32'(pixel_data), 32'h33);
        y_data = 8'd1; cyc();
        check("row1_kept", 32'(pixel_data), 32'h44);

        // Long pending without vsync, double request, request coinciding with vsync.
        swap_req = 1; cyc(); swap_req = 0;
        for (int i = 0; i < 100; i++) begin
            swap_req = (i == 40);
            cyc();
        end
        check("pend_held", 32'(swap_pending), 32'h1);
        vsync = 1; cyc(); vsync = 0;
        check("one_toggle_front", 32'(front_sel), 32'h1);
        repeat (3) begin vsync = 1; cyc(); end
        vsync = 0;
        check("no_extra_toggle", 32'(front_sel), 32'h1);
        swap_req = 1; vsync = 1; cyc();
        swap_req = 0;
        check("req_vsync_same", 32'(front_sel), 32'h1);
        cyc();
        vsync = 0; cyc();
        check("req_vsync_next", 32'(front_sel), 32'h0);

`ifdef DOUBLE_FRAMEBUFFER_CLEAR_EN
        run_fill(8'hE0, "fill_len");
        vsync = 1; cyc(); vsync = 0;
        check("post_fill_swap", 32'(swap_done), 32'h1);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++) begin
                x_data = 8'(xx); y_data = 8'(yy);
                cyc();
            end
        cyc();
        check("fill_last_pixel", 32'(pixel_data), 32'hE0);

        // Asynchronous reset 500 cycles into a fill.
        swap_req = 1; cyc(); swap_req = 0;
        clear_start = 1; clear_color = 8'h1C; cyc(); clear_start = 0;
        repeat (499) cyc();
        #2 rst_n = 0;
        #1;
        model_reset();
        check("arst_pixel", 32'(pixel_data), 32'h0);
        check("arst_front", 32'(front_sel), 32'h0);
        check("arst_pending", 32'(swap_pending), 32'h0);
        check("arst_done", 32'(swap_done), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        run_fill(8'h3C, "fill_after_reset");
`else
        clear_start = 1; clear_color = 8'hE0; cyc();
        clear_start = 0;
        draw(5, 5, 8'h77);
        do_swap();
        x_data = 8'd5; y_data = 8'd5; cyc();
        check("noclear_write", 32'(pixel_data), 32'h77);
`endif

        // Populate a small window in both banks, then random traffic.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 32; i++) draw(i % 8, i / 8, 8'($urandom));
            do_swap();
        end
        for (int i = 0; i < 600; i++) begin
            write    = 1'($urandom_range(0, 1));
            x        = ($urandom_range(0, 9) == 0) ? 8'd170 : 8'($urandom_range(0, 7));
            y        = ($urandom_range(0, 9) == 0) ? 8'd125 : 8'($urandom_range(0, 3));
            color    = 8'($urandom);
            x_data   = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
            y_data   = 8'($urandom_range(0, 3));
            vsync    = ($urandom_range(0, 7) == 0);
            swap_req = ($urandom_range(0, 5) == 0);
            cyc();
        end
        quiet();
        cyc();

        // Wide configuration: corner pixel across a swap.
        ww = 1; wx = 9'd319; wy = 9'd239; wcolor = 16'hBEEF; cyc();
        ww = 0; wsr = 1; cyc();
        wsr = 0; wvs = 1; cyc();
        wvs = 0; wxd = 9'd319; wyd = 9'd239; cyc();
        check("wide_front", 32'(wfront), 32'h1);
        check("wide_corner", 32'(wpixel), 32'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
